i2c_codec_reg_target: RTL and testbench

Synthesizable I2C target that models the audio codec's 2-wire control port, i.e. the far end of the board's I2C configuration master.
- Decodes START/STOP, matches a 7-bit device address and ACKs it, then accepts 16-bit codec words: hi byte {reg[6:0], d[8]}, lo byte d[7:0].
- Commits each word into a 9-bit register file, readable by local logic.
- Used as loopback model and in-system monitor for the codec init sequence.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_codec_reg_target_sampler.sv | 47 ++++
 rtl/i2c_codec_reg_target.sv | 195 +++++++++++++++++++
 tb/tb_i2c_codec_reg_target.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the codec control-port I2C target.
// Also holds the word-packing helper that turns a {reg, data} pair into the two bus bytes.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEV_ADDR = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_BYTE_HI  = 3'd3,
        ST_HI_ACK   = 3'd4,
        ST_BYTE_LO  = 3'd5,
        ST_LO_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_e;

    localparam logic [6:0] REG_LINE_IN_L    = 7'd0;
    localparam logic [6:0] REG_LINE_IN_R    = 7'd1;
    localparam logic [6:0] REG_HP_OUT_L     = 7'd2;
    localparam logic [6:0] REG_HP_OUT_R     = 7'd3;
    localparam logic [6:0] REG_ANALOG_PATH  = 7'd4;
    localparam logic [6:0] REG_DIGITAL_PATH = 7'd5;
    localparam logic [6:0] REG_POWER_DOWN   = 7'd6;
    localparam logic [6:0] REG_DIGITAL_IF   = 7'd7;
    localparam logic [6:0] REG_SAMPLING     = 7'd8;
    localparam logic [6:0] REG_ACTIVE       = 7'd9;
    localparam logic [6:0] REG_RESET        = 7'd15;

    // Returns {hi byte, lo byte}: hi = {reg_idx, data[8]}, lo = data[7:0].
    function automatic logic [15:0] pack_word(input logic [6:0] reg_idx, input logic [8:0] data);
        return {reg_idx, data};
    endfunction

endpackage

// File: rtl/i2c_codec_reg_target_sampler.sv
// Bus sampler: two-flop synchronizers plus a history flop on SCL and SDA,
// producing edge strobes and START/STOP conditions on the synchronized values.
module i2c_bus_sampler (
    input  logic clk,
    input  logic reset,
    input  logic i2c_sclk,
    input  logic i2c_sdat_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    // bit 0 = metastable stage, bit 1 = synchronized value, bit 2 = history
    logic [2:0] scl_q;
    logic [2:0] scl_d;
    logic [2:0] sda_q;
    logic [2:0] sda_d;

    // Shift each pad input into its synchronizer/history chain.
    always_comb begin
        scl_d = {scl_q[1:0], i2c_sclk};
        sda_d = {sda_q[1:0], i2c_sdat_in};
    end

    // Synchronizer flops; idle bus level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= scl_d;
            sda_q <= sda_d;
        end
    end

    // Edge and bus-condition detection on synchronized vs history values.
    always_comb begin
        scl_rise = scl_q[1] & ~scl_q[2];
        scl_fall = ~scl_q[1] & scl_q[2];
        start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
        stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
        sda_s    = sda_q[1];
    end

endmodule

// File: rtl/i2c_codec_reg_target.sv
// I2C target modelling the audio codec control port: address match, 16-bit word
// reception with ACKs, and a 9-bit register file readable by local logic.
module i2c_codec_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A,
    parameter int         NUM_REGS    = 11,
    parameter logic [6:0] RESET_REG   = 7'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    input  logic       i2c_sdat_in,
    output logic       i2c_sdat_oe,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic [7:0] nack_count
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_s;

    i2c_bus_sampler u_sampler (
        .clk        (clk),
        .reset      (reset),
        .i2c_sclk   (i2c_sclk),
        .i2c_sdat_in(i2c_sdat_in),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start      (start),
        .stop       (stop),
        .sda_s      (sda_s)
    );

    state_e     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic [7:0] hi_q,        hi_d;
    logic       ack_drive_q, ack_drive_d;
    logic       sdat_oe_q,   sdat_oe_d;
    logic       busy_q,      busy_d;
    logic [7:0] nack_q,      nack_d;
    logic       wr_valid_q,  wr_valid_d;
    logic [6:0] wr_addr_q,   wr_addr_d;
    logic [8:0] wr_data_q,   wr_data_d;
    logic [8:0] regs_q [NUM_REGS];
    logic [8:0] regs_d [NUM_REGS];

    logic [7:0] byte_s;
    logic       addr_match_s;

    assign byte_s       = {shift_q[6:0], sda_s};
    assign addr_match_s = (byte_s[7:1] == DEVICE_ADDR) && (byte_s[0] == 1'b0);

    // Next-state logic: bus conditions first, then per-state bit/ACK handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hi_d        = hi_q;
        ack_drive_d = ack_drive_q;
        sdat_oe_d   = sdat_oe_q;
        busy_d      = busy_q;
        nack_d      = nack_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;
        if (start) begin
            state_d     = ST_DEV_ADDR;
            bit_cnt_d   = 3'd0;
            busy_d      = 1'b1;
            sdat_oe_d   = 1'b0;
            ack_drive_d = 1'b0;
        end else if (stop) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            busy_d      = 1'b0;
            sdat_oe_d   = 1'b0;
            ack_drive_d = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_BYTE_HI, ST_BYTE_LO: begin
                    if (scl_rise) begin
                        shift_d   = byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_DEV_ADDR) begin
                                if (addr_match_s) begin
                                    state_d = ST_ADDR_ACK;
                                end else begin
                                    state_d = ST_IGNORE;
                                    nack_d  = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
                                end
                            end else if (state_q == ST_BYTE_HI) begin
                                hi_d    = byte_s;
                                state_d = ST_HI_ACK;
                            end else begin
                                state_d    = ST_LO_ACK;
                                wr_valid_d = 1'b1;
                                wr_addr_d  = hi_q[7:1];
                                wr_data_d  = {hi_q[0], byte_s};
                                // Unmapped addresses still pulse wr_valid but leave the file alone.
                                if (int'(hi_q[7:1]) < NUM_REGS) begin
                                    regs_d[hi_q[4:1]] = {hi_q[0], byte_s};
                                end else if (hi_q[7:1] == RESET_REG) begin
                                    regs_d = '{default: 9'd0};
                                end else begin
                                    regs_d = regs_q;
                                end
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_ADDR_ACK, ST_HI_ACK, ST_LO_ACK: begin
                    if (scl_fall) begin
                        if (ack_drive_q) begin
                            ack_drive_d = 1'b0;
                            sdat_oe_d   = 1'b0;
                            bit_cnt_d   = 3'd0;
                            state_d     = (state_q == ST_HI_ACK) ? ST_BYTE_LO : ST_BYTE_HI;
                        end else begin
                            ack_drive_d = 1'b1;
                            sdat_oe_d   = 1'b1;
                        end
                    end else begin
                        ack_drive_d = ack_drive_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control, output and register-file state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            hi_q        <= 8'd0;
            ack_drive_q <= 1'b0;
            sdat_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            nack_q      <= 8'd0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 9'd0;
            regs_q      <= '{default: 9'd0};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hi_q        <= hi_d;
            ack_drive_q <= ack_drive_d;
            sdat_oe_q   <= sdat_oe_d;
            busy_q      <= busy_d;
            nack_q      <= nack_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    // Local read port; indices past the implemented file read as zero.
    always_comb begin
        if (int'(rd_addr) < NUM_REGS) begin
            rd_data = regs_q[rd_addr];
        end else begin
            rd_data = 9'd0;
        end
    end

    assign i2c_sdat_oe = sdat_oe_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign nack_count  = nack_q;

endmodule

// File: tb/tb_i2c_codec_reg_target.sv
// Bench for i2c_codec_reg_target: bit-banged I2C master, transaction-level
// reference model of the codec register file, directed and random transfers.
module tb_i2c_codec_reg_target;
    import i2c_pkg::*;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       i2c_sdat_oe;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       busy;
    logic [7:0] nack_count;

    assign sda_line = sda_m & ~i2c_sdat_oe;

    i2c_codec_reg_target dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_sclk   (scl),
        .i2c_sdat_in(sda_line),
        .i2c_sdat_oe(i2c_sdat_oe),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .nack_count (nack_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int long_pulse = 0;
    int oe_cycles = 0;
    logic wv_prev = 1'b0;

    always @(posedge clk) begin
        if (wr_valid) pulse_cnt <= pulse_cnt + 1;
        if (wr_valid && wv_prev) long_pulse <= long_pulse + 1;
        if (i2c_sdat_oe) oe_cycles <= oe_cycles + 1;
        wv_prev <= wr_valid;
    end

    logic [8:0] mregs [16];
    int         exp_commits = 0;
    logic [6:0] exp_wr_addr = 7'd0;
    logic [8:0] exp_wr_data = 9'd0;
    int         exp_nack = 0;
    logic [7:0] tx [8];
    int         tx_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; waitc(Q);
        scl = 1'b1;   waitc(Q);
        sda_m = 1'b0; waitc(Q);
        scl = 1'b0;   waitc(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; waitc(Q);
        scl = 1'b1;   waitc(Q);
        sda_m = 1'b1; waitc(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;  waitc(Q);
        scl = 1'b1; waitc(2 * Q);
        scl = 1'b0; waitc(Q);
    endtask

    task automatic recv_ack(output logic acked);
        sda_m = 1'b1; waitc(Q);
        scl = 1'b1;   waitc(Q);
        acked = ~sda_line;
        waitc(Q);
        scl = 1'b0;   waitc(Q);
    endtask

    // Codec register-file rules applied to one completed word.
    task automatic model_word(input logic [6:0] a, input logic [8:0] d);
        exp_commits++;
        exp_wr_addr = a;
        exp_wr_data = d;
        if (a < 7'd11) mregs[a[3:0]] = d;
        else if (a == 7'd15) for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
    endtask

    task automatic run_tx();
        logic acked;
        logic addressed;
        int   oe_before;
        oe_before = oe_cycles;
        bus_start();
        check("busy_after_start", 32'(busy), 32'(1));
        addressed = (tx[0] == 8'h34);
        if (!addressed) exp_nack = (exp_nack < 255) ? exp_nack + 1 : 255;
        for (int i = 0; i < tx_len; i++) begin
            for (int b = 7; b >= 0; b--) send_bit(tx[i][b]);
            recv_ack(acked);
            check($sformatf("ack_byte%0d_%02h", i, tx[i]), 32'(acked), 32'(addressed));
            if (addressed && i >= 2 && (i % 2) == 0) model_word(tx[i-1][7:1], {tx[i-1][0], tx[i]});
        end
        bus_stop();
        check("busy_after_stop", 32'(busy), 32'(0));
        if (!addressed) check("sda_never_driven", 32'(oe_cycles - oe_before), 32'(0));
        check("commit_count", 32'(pulse_cnt), 32'(exp_commits));
        check("wr_addr", 32'(wr_addr), 32'(exp_wr_addr));
        check("wr_data", 32'(wr_data), 32'(exp_wr_data));
        check("nack_count", 32'(nack_count), 32'(exp_nack));
    endtask

    task automatic check_regs();
        for (int a = 0; a < 16; a++) begin
            rd_addr = a[3:0];
            waitc(1);
            check($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'((a < 11) ? mregs[a] : 9'd0));
        end
    endtask

    task automatic set_tx(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        tx_len = n;
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3; tx[4] = b4;
    endtask

    initial begin
        logic       acked;
        logic [15:0] w;
        int          nw;
        for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
        waitc(4);
        check("rst_oe", 32'(i2c_sdat_oe), 32'(0));
        check("rst_wr_valid", 32'(wr_valid), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        check("rst_wr_data", 32'(wr_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_nack", 32'(nack_count), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        reset = 1'b0;
        waitc(4);

        // Single word to DIGITAL_IF.
        set_tx(3, 8'h34, 8'h0E, 8'h4D, 8'h00, 8'h00);
        run_tx();
        check_regs();

        // Two streamed words.
        set_tx(5, 8'h34, 8'h08, 8'h11, 8'h10, 8'h00);
        run_tx();
        check_regs();

        // Wrong address, then a read request: both NACKed and ignored.
        set_tx(3, 8'h36, 8'h0E, 8'h4D, 8'h00, 8'h00);
        run_tx();
        set_tx(3, 8'h35, 8'h0E, 8'h4D, 8'h00, 8'h00);
        run_tx();

        // Partial word discarded by STOP.
        set_tx(2, 8'h34, 8'h0E, 8'h00, 8'h00, 8'h00);
        run_tx();
        check_regs();

        // Load a register, then clear the file through the reset register.
        set_tx(3, 8'h34, 8'h00, 8'h18, 8'h00, 8'h00);
        run_tx();
        check_regs();
        set_tx(3, 8'h34, 8'h1E, 8'h00, 8'h00, 8'h00);
        run_tx();
        check_regs();

        // Reset while the target is driving the hi-byte ACK.
        set_tx(3, 8'h34, 8'h0E, 8'h4D, 8'h00, 8'h00);
        run_tx();
        bus_start();
        for (int b = 7; b >= 0; b--) send_bit(tx[0][b]);
        recv_ack(acked);
        for (int b = 7; b >= 0; b--) send_bit(tx[1][b]);
        check("oe_during_hi_ack", 32'(i2c_sdat_oe), 32'(1));
        reset = 1'b1;
        waitc(1);
        check("oe_after_reset", 32'(i2c_sdat_oe), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mregs[i] = 9'd0;
        exp_wr_addr = 7'd0; exp_wr_data = 9'd0; exp_nack = 0;
        recv_ack(acked);
        bus_stop();
        check("no_commit_after_reset", 32'(pulse_cnt), 32'(exp_commits));
        check("busy_after_reset", 32'(busy), 32'(0));
        check("wr_addr_after_reset", 32'(wr_addr), 32'(0));
        run_tx();
        check_regs();

        // Random transfers against the model.
        for (int k = 0; k < 15; k++) begin
            tx[0] = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
            nw = $urandom_range(1, 3);
            tx_len = 1;
            for (int j = 0; j < nw; j++) begin
                w = pack_word(7'($urandom_range(0, 15)), 9'($urandom));
                tx[tx_len] = w[15:8];
                tx[tx_len + 1] = w[7:0];
                tx_len += 2;
            end
            if ($urandom_range(0, 3) == 0) tx_len--;
            run_tx();
        end
        check_regs();
        check("wr_valid_single_cycle", 32'(long_pulse), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
